// File: rtl/norm_out_pkg.sv
// rtl/norm_out_pkg.sv - shared widths, types and helpers for the norm output buffer
package norm_out_pkg;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = AW + 1;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [AW-1:0]     ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DROP_W-1:0] drop_t;

  localparam cnt_t  CNT_FULL = cnt_t'(DEPTH);
  localparam drop_t DROP_MAX = '1;

  function automatic sample_t max_sample(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/norm_out_buffer_if.sv
// rtl/norm_out_buffer_if.sv - valid/ready output stream of the norm output buffer
interface norm_out_if;
  import norm_out_pkg::*;

  sample_t out_data;
  logic    out_valid;
  logic    out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/norm_fifo_mem.sv
// rtl/norm_fifo_mem.sv - DEPTH x DATA_W register array, sync write, async read, no reset
module norm_fifo_mem
  import norm_out_pkg::*;
(
  input  logic    clk,
  input  logic    we,
  input  ptr_t    waddr,
  input  sample_t wdata,
  input  ptr_t    raddr,
  output sample_t rdata
);

  sample_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/norm_out_buffer.sv
// rtl/norm_out_buffer.sv - captures upstream root strobes into a show-ahead FIFO with peak/drop stats
module norm_out_buffer
  import norm_out_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  sample_t    g_in,
  input  logic       valid_in,
  norm_out_if.master out,
  output cnt_t       count,
  output logic       overflow,
  output drop_t      drop_cnt,
  output sample_t    peak,
  input  logic       clr_stats
);

  ptr_t    wr_ptr_q, wr_ptr_d;
  ptr_t    rd_ptr_q, rd_ptr_d;
  cnt_t    count_q, count_d;
  logic    overflow_q, overflow_d;
  drop_t   drop_cnt_q, drop_cnt_d;
  sample_t peak_q, peak_d;
  sample_t peak_base;

  logic not_empty;
  logic pop;
  logic push;
  logic drop;

  // out_valid depends only on registered occupancy, never on out_ready
  assign not_empty = (count_q != '0);
  assign pop       = not_empty & out.out_ready;
  assign push      = valid_in & ((count_q != CNT_FULL) | pop);
  assign drop      = valid_in & ~push;

  norm_fifo_mem u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (g_in),
    .raddr (rd_ptr_q),
    .rdata (out.out_data)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // A drop in the same cycle as clr_stats survives the clear
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_stats) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_stats) begin
        drop_cnt_d = drop_t'(1);
      end else if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_d = drop_cnt_q + drop_t'(1);
      end
    end
  end

  always_comb begin
    peak_base = clr_stats ? '0 : peak_q;
    peak_d    = peak_base;
    if (valid_in) begin
      peak_d = max_sample(peak_base, g_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      peak_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      peak_q     <= peak_d;
    end
  end

  assign out.out_valid = not_empty;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;
  assign peak          = peak_q;

endmodule

// File: tb/tb_norm_out_buffer.sv
// tb/tb_norm_out_buffer.sv - queue-model checked bench for norm_out_buffer
module tb_norm_out_buffer;

  logic       clk;
  logic       reset;
  logic [9:0] g_in;
  logic       valid_in;
  logic       clr_stats;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic [9:0] peak;

  norm_out_if ifc ();

  norm_out_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .g_in      (g_in),
    .valid_in  (valid_in),
    .out       (ifc),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .peak      (peak),
    .clr_stats (clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [9:0] mq[$];
  bit         m_ovf = 1'b0;
  int         m_drop = 0;
  int         m_peak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: apply inputs, advance the model, settle past the edge
  task automatic drive(input bit rst, input bit v, input logic [9:0] g, input bit rdy, input bit clr);
    bit can_pop, accept, dropped;
    reset         = rst;
    valid_in      = v;
    g_in          = g;
    ifc.out_ready = rdy;
    clr_stats     = clr;
    can_pop = (mq.size() > 0) && rdy;
    accept  = v && ((mq.size() < 8) || can_pop);
    dropped = v && !accept;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_drop = 0; m_peak = 0;
    end else begin
      if (can_pop) void'(mq.pop_front());
      if (accept) mq.push_back(g);
      if (clr) begin m_ovf = 1'b0; m_drop = 0; m_peak = 0; end
      if (dropped) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (v && int'(g) > m_peak) m_peak = int'(g);
    end
    #2;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", {31'd0, ifc.out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) chk("out_data", {22'd0, ifc.out_data}, {22'd0, mq[0]});
      chk("count", {28'd0, count}, mq.size());
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
      chk("peak", {22'd0, peak}, m_peak);
    end
  end

  initial begin
    logic [9:0] drain [8];
    int pr, rp;
    reset = 1'b1; valid_in = 1'b0; g_in = '0; ifc.out_ready = 1'b0; clr_stats = 1'b0;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_valid", {31'd0, ifc.out_valid}, 0);
    chk("rst_count", {28'd0, count}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_drop", {24'd0, drop_cnt}, 0);
    chk("rst_peak", {22'd0, peak}, 0);

    // single samples
    drive(0, 1, 21, 1, 0);
    chk("t1_data21", {22'd0, ifc.out_data}, 21);
    chk("t1_valid", {31'd0, ifc.out_valid}, 1);
    drive(0, 1, 41, 1, 0);
    chk("t1_data41", {22'd0, ifc.out_data}, 41);
    drive(0, 0, 0, 1, 0);
    chk("t1_count0", {28'd0, count}, 0);
    chk("t1_peak", {22'd0, peak}, 41);

    // fill, then drop
    drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) drive(0, 1, 10'(i), 0, 0);
    chk("t2_count8", {28'd0, count}, 8);
    chk("t2_head", {22'd0, ifc.out_data}, 1);
    chk("t2_ovf0", {31'd0, overflow}, 0);
    drive(0, 1, 9, 0, 0);
    chk("t2_count_full", {28'd0, count}, 8);
    chk("t2_ovf1", {31'd0, overflow}, 1);
    chk("t2_drop1", {24'd0, drop_cnt}, 1);
    chk("t2_peak9", {22'd0, peak}, 9);

    // full with simultaneous pop and push
    drive(0, 1, 50, 1, 0);
    chk("t3_count8", {28'd0, count}, 8);
    chk("t3_drop1", {24'd0, drop_cnt}, 1);
    drain = '{10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd50};
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", {22'd0, ifc.out_data}, {22'd0, drain[i]});
      drive(0, 0, 0, 1, 0);
    end
    chk("t3_empty", {28'd0, count}, 0);

    // saturation, then clear racing a drop
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 10'(i), 0, 0);
    for (int i = 0; i < 300; i++) drive(0, 1, 10'(i % 100), 0, 0);
    chk("t4_sat", {24'd0, drop_cnt}, 255);
    chk("t4_ovf", {31'd0, overflow}, 1);
    drive(0, 1, 5, 0, 1);
    chk("t4_clr_ovf", {31'd0, overflow}, 1);
    chk("t4_clr_drop", {24'd0, drop_cnt}, 1);
    chk("t4_clr_peak", {22'd0, peak}, 5);

    // empty with push: no bypass
    drive(1, 0, 0, 0, 0);
    chk("t5_pre_valid", {31'd0, ifc.out_valid}, 0);
    drive(0, 1, 76, 1, 0);
    chk("t5_valid", {31'd0, ifc.out_valid}, 1);
    chk("t5_data", {22'd0, ifc.out_data}, 76);

    // reset mid-stream
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 10'(100 + i), 0, 0);
    chk("t6_count5", {28'd0, count}, 5);
    drive(1, 1, 99, 1, 0);
    chk("t6_count0", {28'd0, count}, 0);
    chk("t6_valid0", {31'd0, ifc.out_valid}, 0);
    chk("t6_peak0", {22'd0, peak}, 0);
    chk("t6_ovf0", {31'd0, overflow}, 0);
    drive(0, 1, 86, 0, 0);
    chk("t6_data86", {22'd0, ifc.out_data}, 86);

    // randomized phases with varying consumer pressure
    for (int ph = 0; ph < 4; ph++) begin
      pr = (ph == 0) ? 10 : (ph == 1) ? 50 : (ph == 2) ? 90 : 30;
      for (int i = 0; i < 800; i++) begin
        rp = $urandom_range(0, 99);
        drive($urandom_range(0, 499) == 0,
              $urandom_range(0, 99) < 60,
              10'($urandom_range(0, 1023)),
              rp < pr,
              $urandom_range(0, 99) < 3);
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
